// File: rtl/vsetvl_unit.sv
// rtl/vsetvl_unit.sv - vector configuration (vsetvli/vsetivli/vsetvl) execution unit
//
// Decodes RVV config instructions, computes VLMAX and the new vl, and writes
// the result to the vector CSR block and the scalar register file.
//
// Ports:
//   clk, nrst        clock, asynchronous active-low reset
//   instr_valid      instr/rs1_data/rs2_data valid this cycle
//   instr            32-bit instruction word
//   rs1_data         AVL source
//   rs2_data         vtype source for vsetvl
//   cur_vl           current vl from the vector CSR block
//   instr_ready      unit idle, can accept an instruction
//   vconfig_wr_en    one-cycle CSR write strobe
//   vl_out           new vl
//   vtype_out        new vtype in [30:20], other bits zero
//   rd_wr_en         one-cycle scalar write strobe (rd != x0)
//   rd_addr          scalar destination index
//   rd_data          scalar write value (new vl)
module vsetvl_unit #(
   parameter int VLEN = 512
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        instr_valid,
   input  logic [31:0] instr,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic [31:0] cur_vl,
   output logic        instr_ready,
   output logic        vconfig_wr_en,
   output logic [31:0] vl_out,
   output logic [31:0] vtype_out,
   output logic        rd_wr_en,
   output logic [4:0]  rd_addr,
   output logic [31:0] rd_data
);

   localparam logic [31:0] VLEN_W = 32'(VLEN);

   typedef enum logic [1:0] {IDLE, CALC, WB} state_t;

   state_t      state_q, state_d;
   logic [10:0] vtype_q, vtype_d;
   logic [31:0] avl_q, avl_d;
   logic [4:0]  rd_q, rd_d;
   logic        ready_q, ready_d;
   logic        cfg_wr_q, cfg_wr_d;
   logic        rd_wr_q, rd_wr_d;
   logic [31:0] vl_q, vl_d;
   logic [10:0] vtype_out_q, vtype_out_d;
   logic [4:0]  rd_addr_q, rd_addr_d;

   // Only vtype[10:0] of rs2 is architecturally meaningful here.
   logic unused_rs2;
   assign unused_rs2 = ^rs2_data[31:11];

   // ---------------- decode (IDLE) ----------------
   logic        is_cfg;
   logic        is_vsetivli;
   logic        is_vsetvl;
   logic [10:0] dec_vtype;
   logic [31:0] dec_avl;
   logic [4:0]  dec_rs1;
   logic [4:0]  dec_rd;

   always_comb begin
      dec_rs1     = instr[19:15];
      dec_rd      = instr[11:7];
      is_vsetivli = (instr[31:30] == 2'b11);
      is_vsetvl   = (instr[31:25] == 7'b1000000);
      is_cfg      = (instr[6:0] == 7'b1010111) && (instr[14:12] == 3'b111) &&
                    (!instr[31] || is_vsetivli || is_vsetvl);

      if (is_vsetivli)      dec_vtype = {1'b0, instr[29:20]};
      else if (is_vsetvl)   dec_vtype = rs2_data[10:0];
      else                  dec_vtype = instr[30:20];

      // For vsetivli the rs1 field is the immediate AVL.
      if (is_vsetivli)        dec_avl = {27'd0, dec_rs1};
      else if (dec_rs1 != 0)  dec_avl = rs1_data;
      else if (dec_rd != 0)   dec_avl = 32'hFFFF_FFFF;
      else                    dec_avl = cur_vl;
   end

   // ---------------- VLMAX / vl (CALC) ----------------
   logic [2:0]  vsew;
   logic [2:0]  vlmul;
   logic [31:0] vlmax_base;
   logic [1:0]  frac_sh;
   logic [31:0] vlmax;
   logic        illegal;
   logic [31:0] new_vl;
   logic [10:0] new_vtype;

   always_comb begin
      vsew       = vtype_q[5:3];
      vlmul      = vtype_q[2:0];
      vlmax_base = VLEN_W >> (32'd3 + 32'(vsew[1:0]));
      // 101/110/111 encode LMUL 1/8, 1/4, 1/2 -> right shift of 3/2/1.
      frac_sh    = 2'(~vlmul[1:0]) + 2'd1;
      vlmax      = vlmul[2] ? (vlmax_base >> frac_sh) : (vlmax_base << vlmul[1:0]);
      illegal    = (|vtype_q[10:6]) || vsew[2] || (vlmul == 3'b100) || (vlmax == 32'd0);
      new_vl     = illegal ? 32'd0 : ((avl_q < vlmax) ? avl_q : vlmax);
      new_vtype  = illegal ? 11'h400 : vtype_q;
   end

   // ---------------- next state ----------------
   always_comb begin
      state_d     = state_q;
      vtype_d     = vtype_q;
      avl_d       = avl_q;
      rd_d        = rd_q;
      ready_d     = ready_q;
      cfg_wr_d    = 1'b0;
      rd_wr_d     = 1'b0;
      vl_d        = vl_q;
      vtype_out_d = vtype_out_q;
      rd_addr_d   = rd_addr_q;

      case (state_q)
         IDLE: begin
            // Non-config instructions are consumed silently.
            if (instr_valid && is_cfg) begin
               vtype_d = dec_vtype;
               avl_d   = dec_avl;
               rd_d    = dec_rd;
               ready_d = 1'b0;
               state_d = CALC;
            end
         end
         CALC: begin
            // Result registers are loaded here so they are stable for all of WB
            // and rd_addr/rd_data hold until the next result.
            vl_d        = new_vl;
            vtype_out_d = new_vtype;
            rd_addr_d   = rd_q;
            cfg_wr_d    = 1'b1;
            rd_wr_d     = (rd_q != 5'd0);
            state_d     = WB;
         end
         WB: begin
            ready_d = 1'b1;
            state_d = IDLE;
         end
         default: begin
            ready_d = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= IDLE;
         vtype_q     <= 11'd0;
         avl_q       <= 32'd0;
         rd_q        <= 5'd0;
         ready_q     <= 1'b1;
         cfg_wr_q    <= 1'b0;
         rd_wr_q     <= 1'b0;
         vl_q        <= 32'd0;
         vtype_out_q <= 11'd0;
         rd_addr_q   <= 5'd0;
      end else begin
         state_q     <= state_d;
         vtype_q     <= vtype_d;
         avl_q       <= avl_d;
         rd_q        <= rd_d;
         ready_q     <= ready_d;
         cfg_wr_q    <= cfg_wr_d;
         rd_wr_q     <= rd_wr_d;
         vl_q        <= vl_d;
         vtype_out_q <= vtype_out_d;
         rd_addr_q   <= rd_addr_d;
      end
   end

   assign instr_ready   = ready_q;
   assign vconfig_wr_en = cfg_wr_q;
   assign vl_out        = vl_q;
   assign vtype_out     = {1'b0, vtype_out_q, 20'd0};
   assign rd_wr_en      = rd_wr_q;
   assign rd_addr       = rd_addr_q;
   assign rd_data       = vl_q;

endmodule

// File: doc/vsetvl_unit.md
VSETVL_UNIT -- requirements
Module: vsetvl_unit

Interface
REQ-001 Parameter VLEN, default 512, meaning vector register length in bits; power of two, 128..4096.
REQ-002 clk  input  1  clock; all state updates on posedge.
REQ-003 nrst  input  1  reset, asynchronous, active-low.
REQ-004 instr_valid  input  1  instr, rs1_data and rs2_data are valid this cycle.
REQ-005 instr  input  32  instruction word.
REQ-006 rs1_data  input  32  scalar rs1 value (AVL).
REQ-007 rs2_data  input  32  scalar rs2 value (vtype source for vsetvl).
REQ-008 cur_vl  input  32  current vl from the vector CSR block.
REQ-009 instr_ready  output  1  unit can accept an instruction this cycle.
REQ-010 vconfig_wr_en  output  1  one-cycle write strobe to the vector CSR block.
REQ-011 vl_out  output  32  new vl value for the CSR block.
REQ-012 vtype_out  output  32  new vtype in bits [30:20]; all other bits 0.
REQ-013 rd_wr_en  output  1  one-cycle scalar register write strobe.
REQ-014 rd_addr  output  5  scalar destination register index.
REQ-015 rd_data  output  32  value written to rd (new vl).

Function
REQ-016 A config instruction SHALL be recognised by opcode instr[6:0]=1010111 and funct3 instr[14:12]=111.
- vsetvli: instr[31]=0; vtype=instr[30:20].
- vsetivli: instr[31:30]=11; vtype={1'b0,instr[29:20]}; AVL=instr[19:15] zero-extended.
- vsetvl: instr[31:25]=1000000; vtype=rs2_data[10:0].
REQ-017 The FSM SHALL have states IDLE, CALC and WB; instr_ready=1 only in IDLE.
REQ-018 IDLE: on instr_valid && a config instruction, the unit SHALL capture instr fields, rs1_data, rs2_data and cur_vl, then go to CALC.
- A non-config instruction SHALL be consumed with no state change and no write.
REQ-019 CALC SHALL compute VLMAX and the new vl into registers, then go to WB.
REQ-020 WB SHALL assert vconfig_wr_en for exactly one cycle, assert rd_wr_en iff rd!=0, then return to IDLE.
- Latency: accept at cycle N, strobes at cycle N+2.
- Throughput: one instruction per 3 cycles.
REQ-021 vsew [5:3] encodings: 000/001/010/011 -> SEW 8/16/32/64; 1xx is illegal.
REQ-022 vlmul [2:0] encodings: 000/001/010/011 -> LMUL 1/2/4/8; 101/110/111 -> LMUL 1/8, 1/4, 1/2; 100 is illegal.
REQ-023 Any nonzero vtype bit [10:6] SHALL be illegal.
REQ-024 VLMAX SHALL equal (VLEN/SEW)*LMUL, computed by shifts.
- A fractional LMUL giving VLMAX<1 SHALL be illegal.
REQ-025 AVL selection:
- vsetivli: uimm.
- rs1!=0: rs1_data.
- rs1=0 and rd!=0: 32'hFFFFFFFF.
- rs1=0 and rd=0: captured cur_vl.
REQ-026 Legal vtype: vl=min(AVL,VLMAX), unsigned 32-bit compare; vtype_out[30:20]=vtype.
REQ-027 Illegal vtype: vl=0 and vtype_out[30:20]=11'h400 (vill).
REQ-028 rd_addr=instr[11:7] and rd_data=new vl, held stable from WB through the next accept.
REQ-029 vl_out and vtype_out SHALL be stable across the whole WB cycle, so a negedge-sampling CSR captures them.
REQ-030 cur_vl captured at an accept immediately after a WB SHALL reflect that WB's vl.

Reset
REQ-031 Asserting nrst SHALL force IDLE immediately and clear all outputs to 0 except instr_ready=1.
REQ-032 Reset asserted in CALC or WB SHALL abort the operation with no write strobe after reset.
REQ-033 After nrst deassertion, the first accept SHALL occur on the first posedge with instr_valid=1.

Verification
REQ-034 vsetvli rs1=x1 (100), rd=x2, vtype e32 m1 (0x010) -> cycle N+2: vl_out=16, rd_wr_en=1, rd_addr=2, rd_data=16.
REQ-035 vsetivli uimm=5, rd=x3, vtype e8 m2 (0x001) -> vl_out=5, vtype_out[30:20]=0x001.
REQ-036 vsetvl rs1=x0, rd=x5, rs2_data=0x00F (e16 mf2) -> vl_out=16, rd_data=16.
REQ-037 vsetvli rs1=x0, rd=x0, cur_vl=20, vtype e64 m1 (0x018) -> vl_out=8, rd_wr_en=0, vconfig_wr_en=1.
REQ-038 vtype 0x020 (vsew=100), AVL=10 -> vl_out=0, vtype_out[30:20]=0x400.
REQ-039 nrst pulsed during CALC -> no vconfig_wr_en; instr_ready=1; next instruction gives its correct result.
